// File: rtl/slow_pkg.sv
// Shared constants for the slow-mode timer: state encoding, hold encoding, defaults.
package slow_pkg;

  localparam int unsigned PRESCALE_DEFAULT = 1024;
  localparam int unsigned STATE_W          = 2;
  localparam int unsigned COUNT_W          = 4;
  localparam int unsigned NUM_PERIPH       = 6;

  // FSM encoding; 2'b11 is unused and falls back to IDLE
  localparam logic [STATE_W-1:0] ST_IDLE   = 2'b00;
  localparam logic [STATE_W-1:0] ST_ACTIVE = 2'b01;
  localparam logic [STATE_W-1:0] ST_HOLD   = 2'b10;

  // Hold length value meaning "hold until retrigger or reset"
  localparam logic [COUNT_W-1:0] TIMEOUT_INF = 4'hF;

  // Access hits a peripheral whose slow enable is set
  function automatic logic slow_hit(input logic [NUM_PERIPH-1:0] sel,
                                    input logic [NUM_PERIPH-1:0] en);
    return |(sel & en);
  endfunction

endpackage

// File: rtl/slow_timer_if.sv
// Bus-side signal bundle of the slow-mode timer: access/decode/config in, requests out.
interface slow_timer_if;
  import slow_pkg::*;

  logic               BACT;
  logic               SelIACK, SelVIA, SelIWM, SelSCC, SelSCSI, SelSnd;
  logic               SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd;
  logic               SlowClockGate;
  logic [COUNT_W-1:0] SlowTimeout;
  logic               Slow;
  logic               SlowClkGate;

  // Bus/config side drives the access and configuration, observes the requests
  modport master (
    output BACT,
    output SelIACK, SelVIA, SelIWM, SelSCC, SelSCSI, SelSnd,
    output SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd,
    output SlowClockGate, SlowTimeout,
    input  Slow, SlowClkGate
  );

  // Timer side
  modport slave (
    input  BACT,
    input  SelIACK, SelVIA, SelIWM, SelSCC, SelSCSI, SelSnd,
    input  SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd,
    input  SlowClockGate, SlowTimeout,
    output Slow, SlowClkGate
  );

endinterface

// File: rtl/slow_tick.sv
// Hold-tick prescaler: one-cycle tick every PRESCALE cycles while clr is low.
module slow_tick
  import slow_pkg::*;
#(
  parameter int unsigned PRESCALE = PRESCALE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CNT_W-1:0] cnt;

  // Free-running divider; tick is registered so it is high exactly while cnt == PRESCALE-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      if (cnt == CNT_W'(PRESCALE - 1)) cnt <= '0;
      else                             cnt <= cnt + CNT_W'(1);
      tick <= (cnt == CNT_W'(PRESCALE - 2));
    end
  end

endmodule

// File: rtl/slow_timer.sv
// Forces slow mode on accesses to slow-enabled peripherals and holds it for a
// programmable number of prescaled ticks after the access ends.
module slow_timer
  import slow_pkg::*;
#(
  parameter int unsigned PRESCALE = PRESCALE_DEFAULT
) (
  input  logic CLK,
  input  logic nPOR,
  slow_timer_if.slave bus
);

  logic [STATE_W-1:0] state, state_d;
  logic [COUNT_W-1:0] count, count_d;
  logic               slow, slow_d;
  logic               clk_gate, clk_gate_d;
  logic               hit_c;
  logic               tick;
  logic               tick_clr_c;

  assign hit_c = bus.BACT && slow_hit(
                   {bus.SelSnd,  bus.SelSCSI,  bus.SelSCC,  bus.SelIWM,  bus.SelVIA,  bus.SelIACK},
                   {bus.SlowSnd, bus.SlowSCSI, bus.SlowSCC, bus.SlowIWM, bus.SlowVIA, bus.SlowIACK});

  // Prescaler runs only in HOLD and restarts from zero on every HOLD entry
  assign tick_clr_c = (state != ST_HOLD);

  slow_tick #(.PRESCALE(PRESCALE)) u_tick (
    .clk   (CLK),
    .rst_n (nPOR),
    .clr   (tick_clr_c),
    .tick  (tick)
  );

  // Next-state, hold count and request outputs
  always_comb begin
    state_d = state;
    count_d = count;
    case (state)
      ST_IDLE: begin
        if (hit_c) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (!bus.BACT) begin
          if (bus.SlowTimeout == '0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLD;
            count_d = bus.SlowTimeout;
          end
        end
      end
      ST_HOLD: begin
        if (hit_c) begin
          state_d = ST_ACTIVE;
        end else if (tick && (count != TIMEOUT_INF)) begin
          if (count == COUNT_W'(1)) begin
            state_d = ST_IDLE;
            count_d = '0;
          end else begin
            count_d = count - COUNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
    slow_d     = (state_d != ST_IDLE);
    clk_gate_d = slow_d && bus.SlowClockGate;
  end

  // State and registered request outputs
  always_ff @(posedge CLK or negedge nPOR) begin
    if (!nPOR) begin
      state    <= ST_IDLE;
      count    <= '0;
      slow     <= 1'b0;
      clk_gate <= 1'b0;
    end else begin
      state    <= state_d;
      count    <= count_d;
      slow     <= slow_d;
      clk_gate <= clk_gate_d;
    end
  end

  assign bus.Slow        = slow;
  assign bus.SlowClkGate = clk_gate;

endmodule

// File: tb/tb_slow_timer.sv
// Bench for slow_timer: directed scenarios plus random traffic against a
// cycle-count reference model.
module tb_slow_timer;

  localparam int unsigned P = 4;

  logic       CLK = 1'b0;
  logic       nPOR;
  logic       bact;
  logic [5:0] sel, en;          // bit order: IACK, VIA, IWM, SCC, SCSI, Snd
  logic       gate_en;
  logic [3:0] timeout;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: mode 0 idle, 1 in access, 2 holding with cycles left
  int m_mode;
  int m_rem;
  bit m_inf;
  bit m_slow;
  bit m_gate;

  always #5 CLK = ~CLK;

  slow_timer_if bus ();

  assign bus.BACT          = bact;
  assign bus.SelIACK       = sel[0];
  assign bus.SelVIA        = sel[1];
  assign bus.SelIWM        = sel[2];
  assign bus.SelSCC        = sel[3];
  assign bus.SelSCSI       = sel[4];
  assign bus.SelSnd        = sel[5];
  assign bus.SlowIACK      = en[0];
  assign bus.SlowVIA       = en[1];
  assign bus.SlowIWM       = en[2];
  assign bus.SlowSCC       = en[3];
  assign bus.SlowSCSI      = en[4];
  assign bus.SlowSnd       = en[5];
  assign bus.SlowClockGate = gate_en;
  assign bus.SlowTimeout   = timeout;

  slow_timer #(.PRESCALE(P)) dut (
    .CLK  (CLK),
    .nPOR (nPOR),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_rem = 0; m_inf = 0; m_slow = 0; m_gate = 0;
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge
  task automatic model_edge();
    bit hit;
    if (!nPOR) begin
      model_reset();
      return;
    end
    hit = bact && ((sel & en) != 6'd0);
    case (m_mode)
      0: if (hit) m_mode = 1;
      1: if (!bact) begin
           if (timeout == 4'd0) m_mode = 0;
           else begin
             m_mode = 2;
             m_inf  = (timeout == 4'hF);
             m_rem  = int'(timeout) * int'(P);
           end
         end
      default: begin
        if (hit) m_mode = 1;
        else if (!m_inf) begin
          m_rem--;
          if (m_rem == 0) m_mode = 0;
        end
      end
    endcase
    m_slow = (m_mode != 0);
    m_gate = m_slow && gate_en;
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    check("slow", 32'(bus.Slow), 32'(m_slow));
    check("clkgate", 32'(bus.SlowClkGate), 32'(m_gate));
  endtask

  task automatic idle_inputs();
    bact = 1'b0; sel = 6'd0;
  endtask

  int n;
  bit any;
  bit lo;

  initial begin
    nPOR = 1'b0; bact = 1'b0; sel = 6'd0; en = 6'd0; gate_en = 1'b0; timeout = 4'd0;
    model_reset();
    repeat (3) step();
    check("rst_slow", 32'(bus.Slow), 32'd0);
    check("rst_gate", 32'(bus.SlowClkGate), 32'd0);
    nPOR = 1'b1;
    step();

    // VIA access, 5 cycles, timeout 3 -> 12-cycle hold
    en = 6'b000010; gate_en = 1'b1; timeout = 4'd3;
    bact = 1'b1; sel = 6'b000010;
    step();
    check("via_entry", 32'(bus.Slow), 32'd1);
    check("via_gate", 32'(bus.SlowClkGate), 32'd1);
    repeat (4) step();
    idle_inputs();
    n = 0;
    for (int i = 0; i < 20; i++) begin step(); if (bus.Slow) n++; end
    check("via_hold_len", 32'(n), 32'd12);

    // SCC access with SCC slow disabled
    any = 1'b0;
    bact = 1'b1; sel = 6'b001000;
    for (int i = 0; i < 5; i++) begin step(); any |= bus.Slow; end
    idle_inputs();
    for (int i = 0; i < 3; i++) begin step(); any |= bus.Slow; end
    check("scc_never", 32'(any), 32'd0);

    // IWM access with timeout 0
    en = 6'b000100; timeout = 4'd0;
    bact = 1'b1; sel = 6'b000100;
    repeat (4) step();
    check("iwm_on", 32'(bus.Slow), 32'd1);
    idle_inputs();
    step();
    check("iwm_exit", 32'(bus.Slow), 32'd0);
    repeat (6) step();

    // Retrigger landing on the expiry edge
    en = 6'b000010; timeout = 4'd2;
    bact = 1'b1; sel = 6'b000010;
    repeat (3) step();
    idle_inputs();
    lo = 1'b0;
    for (int i = 0; i < 8; i++) begin step(); lo |= !bus.Slow; end
    bact = 1'b1; sel = 6'b000010;
    step();
    check("retrig_no_gap", 32'(lo || !bus.Slow), 32'd0);
    repeat (2) step();
    idle_inputs();
    n = 0;
    for (int i = 0; i < 16; i++) begin step(); if (bus.Slow) n++; end
    check("retrig_hold_len", 32'(n), 32'd8);

    // Infinite hold, then asynchronous reset mid-HOLD
    timeout = 4'hF;
    bact = 1'b1; sel = 6'b000010;
    repeat (2) step();
    idle_inputs();
    repeat (200) step();
    check("inf_hold", 32'(bus.Slow), 32'd1);
    #2 nPOR = 1'b0;
    #1;
    model_reset();
    check("async_rst_slow", 32'(bus.Slow), 32'd0);
    check("async_rst_gate", 32'(bus.SlowClkGate), 32'd0);
    step();
    nPOR = 1'b1;
    step();

    // Non-slow SCSI access during a 2-tick hold, clock gating disabled
    timeout = 4'd2; gate_en = 1'b0;
    bact = 1'b1; sel = 6'b000010;
    repeat (2) step();
    idle_inputs();
    n = 0; any = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 4) begin bact = 1'b1; sel = 6'b010000; end
      if (i == 7) idle_inputs();
      step();
      if (bus.Slow) n++;
      any |= bus.SlowClkGate;
    end
    check("scsi_hold_len", 32'(n), 32'd8);
    check("gate_off", 32'(any), 32'd0);

    // Random traffic
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        #2 nPOR = 1'b0;
        #1;
        model_reset();
        check("rnd_rst_slow", 32'(bus.Slow), 32'd0);
        step();
        nPOR = 1'b1;
      end
      if (bact) begin
        if ($urandom_range(0, 3) == 0) begin
          bact = 1'b0;
          sel  = 6'($urandom());
        end
      end else begin
        if ($urandom_range(0, 4) == 0) sel = 6'($urandom());
        if ($urandom_range(0, 5) == 0) begin
          bact = 1'b1;
          sel  = 6'd1 << $urandom_range(0, 5);
          if ($urandom_range(0, 3) == 0) sel = 6'($urandom());
        end
      end
      if ($urandom_range(0, 19) == 0) en = 6'($urandom());
      if ($urandom_range(0, 29) == 0) gate_en = 1'($urandom());
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 5))
          0:       timeout = 4'd0;
          1:       timeout = 4'd1;
          2:       timeout = 4'hF;
          3:       timeout = 4'hE;
          default: timeout = 4'($urandom_range(0, 15));
        endcase
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
